// File: rtl/nn_input_loader.sv
// Assembles N_IN streamed words into a double-buffered frame held on in_bus; frame appears the cycle after its last accept.
// s_ready drops only when a completing word would overwrite an unacknowledged held frame.
module nn_input_loader #(
   parameter int N_IN  = 22,
   parameter int W     = 16,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      s_data,
   input  logic              s_valid,
   input  logic              s_last,
   output logic              s_ready,
   output logic [N_IN*W-1:0] in_bus,
   output logic              frame_valid,
   input  logic              frame_ack,
   output logic              frame_err,
   output logic [CNT_W-1:0]  frame_cnt
);
   localparam int IDX_W = $clog2(N_IN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [W-1:0]      fill_q [N_IN];
   logic [W-1:0]      fill_d [N_IN];
   logic [N_IN*W-1:0] in_bus_q, in_bus_d;
   logic              frame_valid_q, frame_valid_d;
   logic              frame_err_q, frame_err_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic              at_last;
   logic              accept;

   assign at_last = (idx_q == LAST_IDX);
   // An ack on the same edge frees the holding register, so completion may proceed.
   assign s_ready = !rst && !(at_last && frame_valid_q && !frame_ack);
   assign accept  = s_valid && s_ready;

   always_comb begin
      idx_d         = idx_q;
      fill_d        = fill_q;
      in_bus_d      = in_bus_q;
      frame_valid_d = frame_valid_q;
      frame_err_d   = 1'b0;
      frame_cnt_d   = frame_cnt_q;

      if (frame_valid_q && frame_ack) begin
         frame_valid_d = 1'b0;
      end

      if (accept) begin
         fill_d[idx_q] = s_data;
         if (at_last) begin
            for (int i = 0; i < N_IN - 1; i++) begin
               in_bus_d[i*W +: W] = fill_q[i];
            end
            in_bus_d[(N_IN-1)*W +: W] = s_data;
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 1'b1;
            idx_d         = '0;
         end else if (s_last) begin
            idx_d       = '0;
            frame_err_d = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q <= '0;
         for (int i = 0; i < N_IN; i++) begin
            fill_q[i] <= '0;
         end
         in_bus_q      <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         idx_q         <= idx_d;
         fill_q        <= fill_d;
         in_bus_q      <= in_bus_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign in_bus      = in_bus_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign frame_cnt   = frame_cnt_q;
endmodule
